// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO of fetch entries; the head entry is a register so the
// outputs to decode carry no combinational path from the ROM.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t head_q;
  fetch_entry_t tail_q;
  logic [1:0]   count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop keeps the count; only the slots shift.
          if (count_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= push_data;
          end else begin
            head_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, ROM request tracking, redirects and decode handshake.
// Define FETCH_ALIGN_CHECK_EN to align redirect targets and flag misalignment.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            misalign_err
);

  // Handshake: decode takes the head entry in any cycle where out_valid and
  // out_ready are both high and no redirect is asserted.

  logic [XLEN-1:0] pc_q;
  logic            inflight_q;
  logic [XLEN-1:0] inflight_pc_q;
  logic [XLEN-1:0] target;
  logic [1:0]      count;
  logic [2:0]      occupancy;
  logic            pop;
  logic            push;
  logic            issue;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_q;

  assign target = {redirect_pc[XLEN-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n)
      misalign_q <= 1'b0;
    else if (redirect_valid && (redirect_pc[1:0] != 2'b00))
      misalign_q <= 1'b1;
  end

  assign misalign_err = misalign_q;
`else
  assign target       = redirect_pc;
  assign misalign_err = 1'b0;
`endif

  assign pop  = out_valid && out_ready && !redirect_valid;
  assign push = inflight_q && !redirect_valid;

  // Entries already buffered or on their way, after this cycle's pop; a new
  // request is only made if its return is guaranteed a FIFO slot.
  assign occupancy = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue     = (occupancy < 3'd2);

  assign push_data.pc    = inflight_pc_q;
  assign push_data.instr = imem_rdata;

  always_comb begin
    imem_addr = pc_q;
    if (!rst_n)              imem_addr = RESET_PC;
    else if (redirect_valid) imem_addr = target;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q          <= target + XLEN'(INSTR_BYTES);
      inflight_q    <= 1'b1;
      inflight_pc_q <= target;
    end else if (issue) begin
      pc_q          <= pc_q + XLEN'(INSTR_BYTES);
      inflight_q    <= 1'b1;
      inflight_pc_q <= pc_q;
    end else begin
      inflight_q    <= 1'b0;
    end
  end

  fetch_skid_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign out_valid = (count != 2'd0);
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

endmodule
